// File: rtl/dm_jtag_pkg.sv
// Shared types for the JTAG debug transport: DMI op/error codes, request FSM states
// and the dtmcs register layout.
package dm_jtag_pkg;

    localparam logic [3:0] DTM_VERSION = 4'd1;

    typedef enum logic [1:0] {
        DTM_NOP   = 2'd0,
        DTM_READ  = 2'd1,
        DTM_WRITE = 2'd2,
        DTM_RSVD  = 2'd3
    } dtm_op_e;

    typedef enum logic [1:0] {
        DMI_NO_ERROR  = 2'd0,
        DMI_RSVD      = 2'd1,
        DMI_OP_FAILED = 2'd2,
        DMI_BUSY      = 2'd3
    } dmi_err_e;

    typedef enum logic [2:0] {
        DmiIdle,
        DmiRead,
        DmiWaitRead,
        DmiWrite,
        DmiWaitWrite
    } dmi_state_e;

    typedef struct packed {
        logic [13:0] zero1;
        logic        dmihardreset;
        logic        dmireset;
        logic        zero0;
        logic [2:0]  idle;
        logic [1:0]  dmistat;
        logic [5:0]  abits;
        logic [3:0]  version;
    } dtmcs_t;

    // Sticky error: a new code only takes effect if it is more severe than the current one.
    function automatic dmi_err_e err_merge(input dmi_err_e cur, input dmi_err_e upd);
        return (upd > cur) ? upd : cur;
    endfunction

endpackage

// File: rtl/dmi_jtag_dr.sv
// tck-domain DR logic of the debug transport: dtmcs and dmi shift registers plus the
// DMI request/response FSM facing the (separately clocked) debug module bridge.
module dmi_jtag_dr
    import dm_jtag_pkg::*;
#(
    parameter int unsigned AddrWidth  = 7,
    parameter int unsigned IdleCycles = 1
) (
    input  logic                 tck_i,
    input  logic                 trst_ni,
    input  logic                 dmi_clear_i,
    input  logic                 capture_i,
    input  logic                 shift_i,
    input  logic                 update_i,
    input  logic                 tdi_i,
    input  logic                 dtmcs_select_i,
    output logic                 dtmcs_tdo_o,
    input  logic                 dmi_select_i,
    output logic                 dmi_tdo_o,
    output logic                 dmi_hardreset_o,
    output logic                 dmi_req_valid_o,
    input  logic                 dmi_req_ready_i,
    output logic [AddrWidth-1:0] dmi_req_addr_o,
    output logic [1:0]           dmi_req_op_o,
    output logic [31:0]          dmi_req_data_o,
    input  logic                 dmi_resp_valid_i,
    output logic                 dmi_resp_ready_o,
    input  logic [31:0]          dmi_resp_data_i,
    input  logic [1:0]           dmi_resp_resp_i
);

    localparam int unsigned DmiWidth = AddrWidth + 34;

    dtmcs_t                dtmcs_q, dtmcs_d;
    logic [DmiWidth-1:0]   dmi_q, dmi_d;
    dmi_state_e            state_q, state_d;
    dmi_err_e              err_q, err_d;
    logic [AddrWidth-1:0]  addr_q, addr_d;
    logic [31:0]           data_q, data_d;
    logic                  hardreset_q, hardreset_d;

    logic   dtmcs_capture, dtmcs_shift, dtmcs_update;
    logic   dmi_capture, dmi_shift, dmi_update;
    logic   busy;
    logic   req_valid, resp_ready;
    logic [1:0] req_op;
    dtmcs_t dtmcs_init;

    assign dtmcs_capture = capture_i & dtmcs_select_i;
    assign dtmcs_shift   = shift_i   & dtmcs_select_i;
    assign dtmcs_update  = update_i  & dtmcs_select_i;
    assign dmi_capture   = capture_i & dmi_select_i;
    assign dmi_shift     = shift_i   & dmi_select_i;
    assign dmi_update    = update_i  & dmi_select_i;
    assign busy          = (state_q != DmiIdle);

    always_comb begin
        dtmcs_init         = '0;
        dtmcs_init.idle    = IdleCycles[2:0];
        dtmcs_init.dmistat = err_q;
        dtmcs_init.abits   = AddrWidth[5:0];
        dtmcs_init.version = DTM_VERSION;
    end

    always_comb begin
        dtmcs_d = dtmcs_q;
        if (dtmcs_capture) begin
            dtmcs_d = dtmcs_init;
        end else if (dtmcs_shift) begin
            dtmcs_d = {tdi_i, dtmcs_q[31:1]};
        end
    end

    // A capture while a transaction is outstanding reports busy in the op field.
    always_comb begin
        dmi_d = dmi_q;
        if (dmi_capture) begin
            dmi_d = {addr_q, data_q, err_q};
            if (busy) begin
                dmi_d[1:0] = DMI_BUSY;
            end
        end else if (dmi_shift) begin
            dmi_d = {tdi_i, dmi_q[DmiWidth-1:1]};
        end
    end

    always_comb begin
        state_d     = state_q;
        err_d       = err_q;
        addr_d      = addr_q;
        data_d      = data_q;
        hardreset_d = 1'b0;
        req_valid   = 1'b0;
        resp_ready  = 1'b0;
        req_op      = DTM_NOP;

        if (dtmcs_update && dtmcs_q.dmireset) begin
            err_d = DMI_NO_ERROR;
        end

        case (state_q)
            DmiIdle: begin
                if (dmi_update && err_q == DMI_NO_ERROR) begin
                    addr_d = dmi_q[DmiWidth-1:34];
                    data_d = dmi_q[33:2];
                    if (dmi_q[1:0] == DTM_READ) begin
                        state_d = DmiRead;
                    end else if (dmi_q[1:0] == DTM_WRITE) begin
                        state_d = DmiWrite;
                    end
                end
            end
            DmiRead: begin
                req_valid = 1'b1;
                req_op    = DTM_READ;
                if (dmi_req_ready_i) begin
                    state_d = DmiWaitRead;
                end
            end
            DmiWrite: begin
                req_valid = 1'b1;
                req_op    = DTM_WRITE;
                if (dmi_req_ready_i) begin
                    state_d = DmiWaitWrite;
                end
            end
            DmiWaitRead: begin
                resp_ready = 1'b1;
                if (dmi_resp_valid_i) begin
                    state_d = DmiIdle;
                    data_d  = dmi_resp_data_i;
                    if (dmi_resp_resp_i == DMI_OP_FAILED) begin
                        err_d = err_merge(err_d, DMI_OP_FAILED);
                    end
                end
            end
            DmiWaitWrite: begin
                resp_ready = 1'b1;
                if (dmi_resp_valid_i) begin
                    state_d = DmiIdle;
                    if (dmi_resp_resp_i == DMI_OP_FAILED) begin
                        err_d = err_merge(err_d, DMI_OP_FAILED);
                    end
                end
            end
            default: state_d = DmiIdle;
        endcase

        if (busy && (dmi_update || dmi_capture)) begin
            err_d = err_merge(err_d, DMI_BUSY);
        end

        // Hard reset abandons the transaction; a response arriving now or later is discarded.
        if (dtmcs_update && dtmcs_q.dmihardreset) begin
            state_d     = DmiIdle;
            err_d       = DMI_NO_ERROR;
            data_d      = data_q;
            hardreset_d = 1'b1;
        end
    end

    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            dtmcs_q     <= '0;
            dmi_q       <= '0;
            state_q     <= DmiIdle;
            err_q       <= DMI_NO_ERROR;
            addr_q      <= '0;
            data_q      <= '0;
            hardreset_q <= 1'b0;
        end else if (dmi_clear_i) begin
            dtmcs_q     <= '0;
            dmi_q       <= '0;
            state_q     <= DmiIdle;
            err_q       <= DMI_NO_ERROR;
            addr_q      <= '0;
            data_q      <= '0;
            hardreset_q <= 1'b0;
        end else begin
            dtmcs_q     <= dtmcs_d;
            dmi_q       <= dmi_d;
            state_q     <= state_d;
            err_q       <= err_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            hardreset_q <= hardreset_d;
        end
    end

    assign dtmcs_tdo_o      = dtmcs_q[0];
    assign dmi_tdo_o        = dmi_q[0];
    assign dmi_hardreset_o  = hardreset_q;
    assign dmi_req_valid_o  = req_valid;
    assign dmi_req_op_o     = req_op;
    assign dmi_req_addr_o   = addr_q;
    assign dmi_req_data_o   = data_q;
    assign dmi_resp_ready_o = resp_ready;

endmodule

// File: tb/tb_dmi_jtag_dr.sv
// Directed bench for dmi_jtag_dr: scans driven at the DR strobe level, a transaction-level
// model compared every cycle, and literal expectations for the key scan results.
module tb_dmi_jtag_dr;

    localparam int AW = 7;
    localparam int W  = AW + 34;
    localparam logic [31:0] DTMCS_BASE = (32'd1 << 12) | (32'd7 << 4) | 32'd1;

    logic          tck = 1'b0;
    logic          trst_ni = 1'b0;
    logic          dmi_clear = 1'b0;
    logic          capture = 1'b0, shift = 1'b0, update = 1'b0, tdi = 1'b0;
    logic          dtmcs_sel = 1'b0, dmi_sel = 1'b0;
    logic          dtmcs_tdo, dmi_tdo, hardreset;
    logic          req_valid, req_ready = 1'b0;
    logic [AW-1:0] req_addr;
    logic [1:0]    req_op;
    logic [31:0]   req_data;
    logic          resp_valid = 1'b0, resp_ready;
    logic [31:0]   resp_data = '0;
    logic [1:0]    resp_resp = '0;

    int checks = 0;
    int errors = 0;

    dmi_jtag_dr #(.AddrWidth(AW), .IdleCycles(1)) dut (
        .tck_i(tck), .trst_ni(trst_ni), .dmi_clear_i(dmi_clear),
        .capture_i(capture), .shift_i(shift), .update_i(update), .tdi_i(tdi),
        .dtmcs_select_i(dtmcs_sel), .dtmcs_tdo_o(dtmcs_tdo),
        .dmi_select_i(dmi_sel), .dmi_tdo_o(dmi_tdo),
        .dmi_hardreset_o(hardreset),
        .dmi_req_valid_o(req_valid), .dmi_req_ready_i(req_ready),
        .dmi_req_addr_o(req_addr), .dmi_req_op_o(req_op), .dmi_req_data_o(req_data),
        .dmi_resp_valid_i(resp_valid), .dmi_resp_ready_o(resp_ready),
        .dmi_resp_data_i(resp_data), .dmi_resp_resp_i(resp_resp)
    );

    always #5 tck = ~tck;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // phase: 0 no transaction, 1 request offered, 2 awaiting response
    logic [31:0]   m_dtmcs = '0;
    logic [W-1:0]  m_dmi = '0;
    logic [AW-1:0] m_addr = '0;
    logic [31:0]   m_data = '0;
    logic [1:0]    m_err = '0;
    int            m_phase = 0;
    logic          m_is_read = 1'b0;
    logic          m_hard = 1'b0;

    function automatic logic [1:0] worse(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic hard_now();
        return dtmcs_sel && update && m_dtmcs[17];
    endfunction

    function automatic logic [1:0] model_err_next();
        logic [1:0] e;
        e = m_err;
        if (dtmcs_sel && update && (m_dtmcs[16] || m_dtmcs[17])) e = 2'd0;
        if (dmi_sel && (capture || update) && m_phase != 0) e = worse(e, 2'd3);
        if (!hard_now() && m_phase == 2 && resp_valid && resp_resp == 2'd2) e = worse(e, 2'd2);
        return e;
    endfunction

    always @(posedge tck or negedge trst_ni) begin
        if (!trst_ni || dmi_clear) begin
            m_dtmcs <= '0; m_dmi <= '0; m_addr <= '0; m_data <= '0;
            m_err <= '0; m_phase <= 0; m_is_read <= 1'b0; m_hard <= 1'b0;
        end else begin
            m_err  <= model_err_next();
            m_hard <= hard_now();
            if (dtmcs_sel && capture) m_dtmcs <= DTMCS_BASE | {20'b0, m_err, 10'b0};
            else if (dtmcs_sel && shift) m_dtmcs <= {tdi, m_dtmcs[31:1]};
            if (dmi_sel && capture) m_dmi <= {m_addr, m_data, (m_phase != 0) ? 2'd3 : m_err};
            else if (dmi_sel && shift) m_dmi <= {tdi, m_dmi[W-1:1]};
            if (dmi_sel && update && m_err == 2'd0 && m_phase == 0) begin
                m_addr <= m_dmi[W-1:34];
                m_data <= m_dmi[33:2];
                if (m_dmi[1:0] == 2'd1) begin m_phase <= 1; m_is_read <= 1'b1; end
                else if (m_dmi[1:0] == 2'd2) begin m_phase <= 1; m_is_read <= 1'b0; end
            end
            if (hard_now()) m_phase <= 0;
            else if (m_phase == 1 && req_ready) m_phase <= 2;
            else if (m_phase == 2 && resp_valid) begin
                m_phase <= 0;
                if (m_is_read) m_data <= resp_data;
            end
        end
    end

    always @(negedge tck) begin
        if (trst_ni) begin
            check("req_valid", req_valid, m_phase == 1);
            check("req_op", req_op, (m_phase == 1) ? (m_is_read ? 2'd1 : 2'd2) : 2'd0);
            check("resp_ready", resp_ready, m_phase == 2);
            check("hardreset", hardreset, m_hard);
            check("dtmcs_tdo", dtmcs_tdo, m_dtmcs[0]);
            check("dmi_tdo", dmi_tdo, m_dmi[0]);
            if (m_phase == 1) begin
                check("req_addr", req_addr, m_addr);
                check("req_data", req_data, m_data);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge tck);
        #2;
    endtask

    task automatic dtmcs_scan(input logic [31:0] din, output logic [31:0] dout);
        dtmcs_sel = 1'b1;
        capture = 1'b1; tick(); capture = 1'b0;
        shift = 1'b1;
        for (int i = 0; i < 32; i++) begin
            dout[i] = dtmcs_tdo;
            tdi = din[i];
            tick();
        end
        shift = 1'b0; tdi = 1'b0;
        update = 1'b1; tick(); update = 1'b0;
        dtmcs_sel = 1'b0;
    endtask

    task automatic dmi_scan(input logic [W-1:0] din, output logic [W-1:0] dout);
        dmi_sel = 1'b1;
        capture = 1'b1; tick(); capture = 1'b0;
        shift = 1'b1;
        for (int i = 0; i < W; i++) begin
            dout[i] = dmi_tdo;
            tdi = din[i];
            tick();
        end
        shift = 1'b0; tdi = 1'b0;
        update = 1'b1; tick(); update = 1'b0;
        dmi_sel = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 50 && !req_valid; i++) tick();
        check(name, req_valid, 1'b1);
    endtask

    task automatic accept();
        req_ready = 1'b1; tick(); req_ready = 1'b0;
    endtask

    task automatic respond(input logic [31:0] d, input logic [1:0] r);
        resp_data = d; resp_resp = r; resp_valid = 1'b1;
        tick();
        resp_valid = 1'b0; resp_resp = 2'd0;
    endtask

    task automatic check_all_zero(input string name);
        check(name, {req_valid, resp_ready, req_op, req_addr, req_data, hardreset,
                     dtmcs_tdo, dmi_tdo}, '0);
    endtask

    logic [31:0]  dt_out;
    logic [W-1:0] dm_out;

    initial begin
        #23;
        check_all_zero("reset_outputs");
        trst_ni = 1'b1;
        tick();

        // dtmcs identification after reset
        dtmcs_scan(32'h0, dt_out);
        check("dtmcs_reset_value", dt_out, 32'h0000_1071);

        // plain read, OK response
        dmi_scan({7'h10, 32'h0, 2'd1}, dm_out);
        wait_valid("read_valid");
        check("read_addr", req_addr, 7'h10);
        check("read_op", req_op, 2'd1);
        accept();
        respond(32'hDEAD_BEEF, 2'd0);
        dmi_scan('0, dm_out);
        check("read_result", dm_out, {7'h10, 32'hDEAD_BEEF, 2'b00});

        // busy: capture while the request is stalled
        dmi_scan({7'h05, 32'h1234_5678, 2'd2}, dm_out);
        wait_valid("write_valid");
        dmi_scan({7'h06, 32'h0000_AAAA, 2'd1}, dm_out);
        check("busy_capture", dm_out, {7'h05, 32'h1234_5678, 2'b11});
        accept();
        respond(32'h0, 2'd0);
        dmi_scan({7'h07, 32'h0, 2'd1}, dm_out);
        check("sticky_busy_op", dm_out[1:0], 2'd3);
        repeat (3) tick();
        check("busy_update_ignored", req_valid, 1'b0);
        dtmcs_scan(32'h0001_0000, dt_out);
        check("dtmcs_dmistat_busy", dt_out, 32'h0000_1C71);
        dmi_scan({7'h07, 32'h0, 2'd1}, dm_out);
        check("after_dmireset", dm_out, {7'h05, 32'h1234_5678, 2'b00});
        wait_valid("read2_valid");
        check("read2_addr", req_addr, 7'h07);
        accept();
        respond(32'hCAFE_0001, 2'd0);

        // failed write
        dmi_scan({7'h11, 32'h0BAD_F00D, 2'd2}, dm_out);
        check("pre_fail_capture", dm_out, {7'h07, 32'hCAFE_0001, 2'b00});
        wait_valid("fail_write_valid");
        accept();
        respond(32'h0, 2'd2);
        dtmcs_scan(32'h0, dt_out);
        check("dtmcs_dmistat_failed", dt_out, 32'h0000_1871);
        dmi_scan({7'h12, 32'h7777_0000, 2'd1}, dm_out);
        check("failed_capture", dm_out, {7'h11, 32'h0BAD_F00D, 2'b10});
        repeat (3) tick();
        check("failed_update_ignored", req_valid, 1'b0);
        dtmcs_scan(32'h0001_0000, dt_out);
        check("dtmcs_failed_again", dt_out, 32'h0000_1871);

        // hard reset while waiting for a read response
        dmi_scan({7'h12, 32'h7777_0000, 2'd1}, dm_out);
        check("restored_capture", dm_out, {7'h11, 32'h0BAD_F00D, 2'b00});
        wait_valid("hr_read_valid");
        check("hr_read_addr", req_addr, 7'h12);
        accept();
        check("hr_wait_ready", resp_ready, 1'b1);
        dtmcs_scan(32'h0002_0000, dt_out);
        check("dtmcs_before_hr", dt_out, 32'h0000_1071);
        check("hr_pulse_high", hardreset, 1'b1);
        check("hr_resp_ready_low", resp_ready, 1'b0);
        tick();
        check("hr_pulse_low", hardreset, 1'b0);
        respond(32'h5555_AAAA, 2'd2);
        dmi_scan({7'h13, 32'h1111_2222, 2'd2}, dm_out);
        check("late_resp_ignored", dm_out, {7'h12, 32'h7777_0000, 2'b00});

        // synchronous clear mid-write
        wait_valid("clr_write_valid");
        check("clr_write_data", req_data, 32'h1111_2222);
        dmi_clear = 1'b1; tick();
        check_all_zero("clear_outputs");
        dmi_clear = 1'b0;
        dmi_scan({7'h14, 32'h3333_4444, 2'd2}, dm_out);
        check("after_clear_capture", dm_out, '0);

        // asynchronous reset mid-write
        wait_valid("rst_write_valid");
        trst_ni = 1'b0;
        #1;
        check_all_zero("async_reset_outputs");
        tick();
        respond(32'h9999_9999, 2'd0);
        trst_ni = 1'b1;
        tick();
        dtmcs_scan(32'h0, dt_out);
        check("dtmcs_after_reset", dt_out, 32'h0000_1071);
        dmi_scan('0, dm_out);
        check("dmi_after_reset", dm_out, '0);

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
